// File: rtl/mode_sequencer.sv
// Mode sequencer: selects one of NUM_MODES channels, routes controls to it and muxes its time back.
// Define MODE_SEQUENCER_TIMEOUT_EN to add the inactivity counter with automatic return to mode 0.
module mode_sequencer #(
  parameter int unsigned NUM_MODES  = 4,
  parameter int unsigned TIMEOUT_MS = 30000
) (
  input  logic                    i_clk,
  input  logic                    i_rstn,
  input  logic                    i_ms_pulse,
  input  logic                    i_mode,
  input  logic                    i_mode_back,
  input  logic                    i_set,
  input  logic [3:0]              i_btn,
  input  logic [NUM_MODES-1:0]    i_mode_mask,
  input  logic [NUM_MODES*17-1:0] i_mode_data,
  output logic [NUM_MODES*5-1:0]  o_ch_ctrl,
  output logic [5:0]              o_sec,
  output logic [5:0]              o_min,
  output logic [4:0]              o_hr,
  output logic [2:0]              o_mode_idx,
  output logic                    o_timeout
);

  logic [2:0] mode_q, mode_d;
  logic [2:0] mode_up, mode_dn;
  logic [7:0] mask_ext;
  logic       mode_req;
  logic       timeout_fire;

  // Padded to 8 bits so a 3-bit index is always in range; mode 0 is always selectable.
  always_comb begin
    mask_ext                  = '0;
    mask_ext[NUM_MODES-1:0]   = i_mode_mask;
    mask_ext[0]               = 1'b1;
  end

  always_comb begin
    mode_up = '0;
    for (int k = int'(NUM_MODES) - 1; k >= 0; k--) begin
      if (k > int'(mode_q) && mask_ext[k[2:0]]) mode_up = k[2:0];
    end
    // Highest enabled overall first, then overridden by highest enabled below current.
    mode_dn = '0;
    for (int k = 0; k < int'(NUM_MODES); k++) begin
      if (mask_ext[k[2:0]]) mode_dn = k[2:0];
    end
    for (int k = 0; k < int'(NUM_MODES); k++) begin
      if (k < int'(mode_q) && mask_ext[k[2:0]]) mode_dn = k[2:0];
    end
  end

  assign mode_req = i_mode ^ i_mode_back;

  always_comb begin
    mode_d = mode_q;
    if (!mask_ext[mode_q]) begin
      mode_d = '0;
    end else if (!i_set && mode_req) begin
      mode_d = i_mode ? mode_up : mode_dn;
    end else if (timeout_fire) begin
      mode_d = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) mode_q <= '0;
    else         mode_q <= mode_d;
  end

`ifdef MODE_SEQUENCER_TIMEOUT_EN
  localparam int unsigned   CntW   = $clog2(TIMEOUT_MS + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_MS);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            activity;

  // Any mode request, even one that is ignored or cancels out, pre-empts the timeout.
  assign timeout_fire = i_rstn && (cnt_q == CntMax) && !(i_mode || i_mode_back) &&
                        mask_ext[mode_q] && (mode_q != '0);

  always_comb begin
    activity = (|i_btn) || i_set || i_mode || i_mode_back;
    cnt_d    = cnt_q;
    if (activity || (mode_d != mode_q) || (mode_q == '0)) begin
      cnt_d = '0;
    end else if (i_ms_pulse && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
`else
  logic unused_ms_pulse;
  assign unused_ms_pulse = i_ms_pulse;
  assign timeout_fire    = 1'b0;
`endif

  assign o_timeout  = timeout_fire;
  assign o_mode_idx = mode_q;

  always_comb begin
    o_ch_ctrl = '0;
    o_hr      = '0;
    o_min     = '0;
    o_sec     = '0;
    for (int k = 0; k < int'(NUM_MODES); k++) begin
      if (mode_q == k[2:0]) begin
        o_ch_ctrl[5*k +: 5]   = {i_set, i_btn};
        {o_hr, o_min, o_sec}  = i_mode_data[17*k +: 17];
      end
    end
  end

endmodule
